booth_mult_arb: RTL and testbench

- Shares one booth_mult_ver_syn instance (16x16 signed, 32-bit product) between NUM_REQ requester ports.
- Arbitrates round-robin, latches the winner's operands and issues one multiply.
- Waits for the multiplier's done indication and returns the product tagged with the requester index.
- Sits between the processing clients and the multiplier; a watchdog flags a multiplier that never completes.

---
 rtl/booth_mult_arb.sv | 152 +++++++++++++++
 tb/tb_booth_mult_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arb.sv
// booth_mult_arb: round-robin arbiter sharing one signed multiplier between
// NUM_REQ requesters. One operation is in flight at a time; the product is
// returned tagged with the requester index, or as an error response when the
// multiplier fails to finish within TIMEOUT cycles.
module booth_mult_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_c,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    output logic                     mult_start,
    input  logic                     mult_ready,
    input  logic [2*WIDTH-1:0]       mult_c,
    output logic                     busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]     mult_a_q, mult_a_d;
    logic [WIDTH-1:0]     mult_b_q, mult_b_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_c_q, rsp_c_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      cand;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Accept strobe: only the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        rsp_id_d  = rsp_id_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    mult_a_d = req_a[grant_id*WIDTH +: WIDTH];
                    mult_b_d = req_b[grant_id*WIDTH +: WIDTH];
                    rsp_id_d = grant_id;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion in the final watchdog cycle still counts as success.
                if (mult_ready) begin
                    rsp_c_d   = mult_c;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            timer_q   <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            rsp_id_q  <= '0;
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            rsp_id_q  <= rsp_id_d;
            rsp_c_q   <= rsp_c_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_start = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_arb.sv
// Bench for booth_mult_arb: requester driver with a round-robin reference
// model, a behavioural multiplier stub with programmable latency, and a
// response monitor that checks against a scoreboard queue.
`timescale 1ns/1ps
module tb_booth_mult_arb;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_c;
    logic                     rsp_err;
    logic [WIDTH-1:0]         mult_a;
    logic [WIDTH-1:0]         mult_b;
    logic                     mult_start;
    logic                     mult_ready = 1'b0;
    logic [2*WIDTH-1:0]       mult_c = '0;
    logic                     busy;

    booth_mult_arb #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .rsp_err    (rsp_err),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_start (mult_start),
        .mult_ready (mult_ready),
        .mult_c     (mult_c),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] c;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   dut_order[$];

    int n_vec = 0;
    int n_err = 0;

    // requester-side state
    logic                    pend_v [NUM_REQ];
    logic signed [WIDTH-1:0] pend_a [NUM_REQ];
    logic signed [WIDTH-1:0] pend_b [NUM_REQ];
    bit refill    = 0;
    bit rand_mode = 0;
    bit rand_bp   = 0;

    // reference model state
    int               model_rr  = 0;
    bit               in_flight = 0;
    int               free_cyc  = 0;
    int               grant_cyc = -100;
    int               n_grants  = 0;
    int               fixed_lat = 1;
    logic [WIDTH-1:0] cur_a = '0;
    logic [WIDTH-1:0] cur_b = '0;

    // monitor state
    int bp_hold   = 0;
    int hold_left = 0;
    bit seen      = 0;

    // multiplier stub: latency 1 means done visible in the first WAIT cycle, 0 means never
    int stub_lat = 1;
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (mult_start) begin
            mult_c     <= 32'(int'($signed(mult_a)) * int'($signed(mult_b)));
            mult_ready <= (stub_lat == 1);
            stub_cnt   <= (stub_lat > 1) ? stub_lat - 1 : 0;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) mult_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < NUM_REQ; i++) r |= pend_v[i];
        return r;
    endfunction

    task automatic set_req(input int p, input int a, input int b);
        pend_v[p] = 1'b1;
        pend_a[p] = WIDTH'(a);
        pend_b[p] = WIDTH'(b);
    endtask

    // One clock: drive inputs at negedge, then check and predict the grant.
    task automatic step(input bit do_rst);
        int                 g;
        int                 lat;
        logic [NUM_REQ-1:0] exp_rdy;
        bit                 exp_busy;
        exp_t               e;
        @(negedge clk);
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, int'($urandom), int'($urandom));
                end else if (pend_v[i] && $urandom_range(0, 15) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
        end
        rst = do_rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = pend_v[i];
            req_a[i*WIDTH +: WIDTH]   = pend_a[i];
            req_b[i*WIDTH +: WIDTH]   = pend_b[i];
        end
        #2;
        if (do_rst) begin
            sb.delete();
            in_flight = 0;
            model_rr  = 0;
            grant_cyc = -100;
            free_cyc  = cyc + 1;
            seen      = 0;
            hold_left = 0;
            return;
        end
        g       = -1;
        exp_rdy = '0;
        if (!in_flight && cyc >= free_cyc) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && pend_v[(model_rr + k) % NUM_REQ]) g = (model_rr + k) % NUM_REQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_busy = in_flight || (cyc < free_cyc);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("mult_start", 64'(mult_start), 64'(cyc == grant_cyc + 1));
        if (cyc == grant_cyc + 1) begin
            chk("mult_a", 64'(mult_a), 64'(cur_a));
            chk("mult_b", 64'(mult_b), 64'(cur_b));
        end
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) dut_order.push_back(i);
        if (g >= 0) begin
            if (rand_mode) lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
            else           lat = fixed_lat;
            e.id  = g;
            e.err = (lat == 0 || lat > TIMEOUT);
            e.c   = e.err ? 32'd0 : 32'(int'(pend_a[g]) * int'(pend_b[g]));
            e.due = cyc + 2 + (e.err ? TIMEOUT : lat);
            sb.push_back(e);
            cur_a     = pend_a[g];
            cur_b     = pend_b[g];
            stub_lat  = lat;
            in_flight = 1;
            grant_cyc = cyc;
            n_grants++;
            if (refill) set_req(g, int'($urandom), int'($urandom));
            else        pend_v[g] = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_flight || any_pend()) && n < budget) begin
            step(0);
            n++;
        end
        if (in_flight || any_pend()) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got still busy after %0d cycles expected idle", budget);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_c", 64'(rsp_c), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_mult_a", 64'(mult_a), 64'(0));
        chk("rst_mult_b", 64'(mult_b), 64'(0));
    endtask

    // Response monitor: pops the scoreboard on each handshake.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                        rsp_ready = 1'b1;
                    end else begin
                        if (!seen) begin
                            seen = 1;
                            chk("rsp_latency", 64'(cyc), 64'(sb[0].due));
                            if (bp_hold > 0) hold_left = bp_hold;
                            else if (rand_bp && $urandom_range(0, 3) == 0) hold_left = int'($urandom_range(1, 4));
                            else hold_left = 0;
                            bp_hold = 0;
                        end
                        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                        chk("rsp_c", 64'(rsp_c), 64'(sb[0].c));
                        chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
                        chk("busy_in_resp", 64'(busy), 64'(1));
                        if (hold_left == 0) begin
                            rsp_ready = 1'b1;
                            model_rr  = (sb[0].id + 1) % NUM_REQ;
                            void'(sb.pop_front());
                            in_flight = 0;
                            free_cyc  = cyc + 1;
                            seen      = 0;
                        end else begin
                            rsp_ready = 1'b0;
                            hold_left--;
                        end
                    end
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (sb.size() > 0 && !seen && cyc > sb[0].due) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_late: got no response expected one at cycle %0d (cycle %0d)", sb[0].due, cyc);
                        void'(sb.pop_front());
                        in_flight = 0;
                        free_cyc  = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion by 2ms");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int n0;
        int budget;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        step(1);
        step(1);
        step(0);
        chk_reset_vals();

        // directed single requests, including latency at the watchdog edge
        fixed_lat = 1;       set_req(0, 7, 4);   drain(40);
        fixed_lat = 2;       set_req(1, 5, -5);  drain(40);
        fixed_lat = 3;       set_req(2, -7, 1);  drain(40);
        fixed_lat = TIMEOUT; set_req(3, -5, -5); drain(TIMEOUT + 20);

        // all ports continuously valid
        dut_order.delete();
        fixed_lat = 1;
        refill    = 1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, int'($urandom), int'($urandom));
        n0     = n_grants;
        budget = 0;
        while (n_grants - n0 < 6 && budget < 200) begin
            step(0);
            budget++;
        end
        refill = 0;
        drain(200);
        if (dut_order.size() < 6) begin
            n_vec++;
            n_err++;
            $display("FAIL rr_order_len: got %0d grants expected at least 6", dut_order.size());
        end else begin
            for (int k = 0; k < 6; k++) chk("rr_order", 64'(dut_order[k]), 64'(exp_order[k]));
        end

        // response backpressure with another requester waiting
        bp_hold   = 10;
        fixed_lat = 2;
        set_req(3, 1234, -321);
        set_req(1, -32768, -32768);
        drain(80);

        // watchdog: just past the limit, never done, then a normal one
        fixed_lat = TIMEOUT + 1; set_req(3, 100, 200); drain(TIMEOUT + 30);
        fixed_lat = 0;           set_req(0, 3, 3);     drain(TIMEOUT + 30);
        fixed_lat = 2;           set_req(2, -1, 32767); drain(40);

        // reset while waiting on the multiplier
        fixed_lat = 5;
        set_req(1, 11, 13);
        step(0);
        step(0);
        step(0);
        step(1);
        step(0);
        chk_reset_vals();
        fixed_lat = 3;
        set_req(2, -300, 45);
        set_req(3, 9, 9);
        drain(60);

        // random traffic with random backpressure
        rand_mode = 1;
        rand_bp   = 1;
        for (int i = 0; i < 1500; i++) step(0);
        rand_mode = 0;
        drain(600);
        rand_bp = 0;
        step(0);
        step(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
